wishbone_host_master: RTL and testbench

Wishbone initiator that turns single-word host commands into classic Wishbone cycles on the master port of the bus interconnect, and returns the read data or an error status. It sits between the host command decoder and the interconnect's `m_*` port. It has a bus timeout because the interconnect returns no ack for unmapped slave selects. It also edge-detects and latches the interconnect's aggregate interrupt line.

---
 rtl/wishbone_host_master.sv | 140 ++++++++++++++
 tb/tb_wishbone_host_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_host_master.sv
// Wishbone host master: single-word host commands to classic Wishbone
// cycles, with a bus watchdog and a latched interrupt-pending flag.
module wishbone_host_master #(
  parameter logic [15:0] TIMEOUT = 16'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_stb_i,
  output logic        cmd_rdy_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_stb_o,
  input  logic        rsp_rdy_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_int_i,
  output logic        int_pend_o,
  input  logic        int_clr_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdat_q, rdat_d;
  logic        rerr_q, rerr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        int_dly_q, int_dly_d;
  logic        pend_q, pend_d;
  logic        tmo_hit;

  assign tmo_hit = (TIMEOUT != 16'd0) &&
                   (cnt_q == TIMEOUT - 16'd1);

  assign cmd_rdy_o  = (state_q == S_IDLE);
  assign wb_cyc_o   = (state_q == S_BUS);
  assign wb_stb_o   = (state_q == S_BUS);
  assign rsp_stb_o  = (state_q == S_RESP);
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign rsp_dat_o  = rdat_q;
  assign rsp_err_o  = rerr_q;
  assign int_pend_o = pend_q;

  // Next-state: command capture, bus cycle with watchdog, response hold
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_stb_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cnt_d   = 16'd0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_ack_i || tmo_hit) begin
          rdat_d  = (wb_ack_i && !we_q) ? wb_dat_i : 32'd0;
          rerr_d  = !wb_ack_i;
          we_d    = 1'b0;
          adr_d   = 32'd0;
          dat_d   = 32'd0;
          sel_d   = 4'd0;
          state_d = S_RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_rdy_i) begin
          rdat_d  = 32'd0;
          rerr_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Interrupt: rising edge sets the flag, and wins over a same-cycle clear
  always_comb begin
    int_dly_d = wb_int_i;
    pend_d    = (wb_int_i & ~int_dly_q) | (pend_q & ~int_clr_i);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      rdat_q    <= 32'd0;
      rerr_q    <= 1'b0;
      cnt_q     <= 16'd0;
      int_dly_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rdat_q    <= rdat_d;
      rerr_q    <= rerr_d;
      cnt_q     <= cnt_d;
      int_dly_q <= int_dly_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_wishbone_host_master.sv
// Testbench for wishbone_host_master: vector table, random traffic
// against a transaction-level model, and hand-written corner cases.
module tb_wishbone_host_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_stb, cmd_rdy, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_stb, rsp_rdy, rsp_err;
  logic [31:0] rsp_dat;
  logic        wb_we, wb_cyc, wb_stb;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_ack;
  logic        wb_int, int_pend, int_clr;

  int errors = 0;
  int checks = 0;

  int ack_at = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  wishbone_host_master #(.TIMEOUT(16'(T))) dut (
    .clk(clk), .rst(rst),
    .cmd_stb_i(cmd_stb), .cmd_rdy_o(cmd_rdy),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_stb_o(rsp_stb), .rsp_rdy_i(rsp_rdy),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_sel_o(wb_sel), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack),
    .wb_int_i(wb_int), .int_pend_o(int_pend), .int_clr_i(int_clr)
  );

  // Slave: acks combinationally on the ack_at-th cycle of cyc (0 = never)
  always @(posedge clk)
    if (rst || !wb_cyc) cyc_n <= 0;
    else cyc_n <= cyc_n + 1;
  assign wb_ack = wb_stb && (ack_at != 0) && (cyc_n == ack_at - 1);

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack;
    logic [31:0] rdata;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: ack within the watchdog wins, else timeout
  function automatic void model(input int ack, input logic we,
                                input logic [31:0] rdata,
                                output int cyc, output logic err,
                                output logic [31:0] dat);
    if (ack != 0 && ack <= T) begin
      cyc = ack;
      err = 1'b0;
      dat = we ? 32'd0 : rdata;
    end else begin
      cyc = T;
      err = 1'b1;
      dat = 32'd0;
    end
  endfunction

  task automatic txn(input vec_t v);
    int   n;
    logic held;
    chk("idle_rdy", 32'(cmd_rdy), 32'd1);
    cmd_we   = v.we;
    cmd_adr  = v.adr;
    cmd_dat  = v.dat;
    cmd_sel  = v.sel;
    ack_at   = v.ack;
    wb_dat_i = v.rdata;
    rsp_rdy  = 1'b0;
    cmd_stb  = 1'b1;
    tick();
    cmd_stb  = 1'b0;
    cmd_adr  = ~v.adr;
    cmd_dat  = ~v.dat;
    n    = 0;
    held = 1'b1;
    while (wb_cyc && n < 64) begin
      if (!wb_stb || wb_adr !== v.adr || wb_dat_o !== v.dat ||
          wb_we !== v.we || wb_sel !== v.sel || cmd_rdy)
        held = 1'b0;
      n++;
      tick();
    end
    chk("cyc_len", 32'(n), 32'(v.exp_cyc));
    chk("bus_held", 32'(held), 32'd1);
    chk("rsp_stb", 32'(rsp_stb), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_dat", rsp_dat, v.exp_dat);
    chk("adr_zero", wb_adr, 32'd0);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    ack_at  = 0;
    chk("rsp_done", 32'(rsp_stb), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] hold_dat;
    rst = 1'b1;
    cmd_stb = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_rdy = 1'b0; wb_dat_i = '0;
    wb_int = 1'b0; int_clr = 1'b0;

    vecs[0] = '{1'b1, 32'h0100_0010, 32'hA5A5_1234, 4'hF, 3,
                32'h0, 3, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, 4'hF, 1,
                32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D};
    vecs[2] = '{1'b0, 32'h0200_0000, 32'h0, 4'hF, 0,
                32'h1234_5678, 8, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0200_0000, 32'h0, 4'hF, 8,
                32'h1357_9BDF, 8, 1'b0, 32'h1357_9BDF};
    vecs[4] = '{1'b0, 32'h0300_0008, 32'h0, 4'h3, 9,
                32'hFFFF_FFFF, 8, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h0400_0020, 32'h0BAD_BEEF, 4'h1, 2,
                32'hDEAD_DEAD, 2, 1'b0, 32'h0};

    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_rsp", 32'(rsp_stb), 32'd0);
    chk("rst_dat", rsp_dat, 32'd0);
    chk("rst_int", 32'(int_pend), 32'd0);

    for (int i = 0; i < 6; i++) begin
      txn(vecs[i]);
    end

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.adr   = $urandom;
      v.dat   = $urandom;
      v.sel   = 4'($urandom_range(0, 15));
      v.ack   = $urandom_range(0, 10);
      v.rdata = $urandom;
      model(v.ack, v.we, v.rdata, v.exp_cyc, v.exp_err, v.exp_dat);
      txn(v);
    end

    // Backpressure while a second command waits
    cmd_we = 1'b0; cmd_adr = 32'h0000_0040; cmd_sel = 4'hF;
    ack_at = 1; wb_dat_i = 32'h0F0F_0F0F; rsp_rdy = 1'b0;
    cmd_stb = 1'b1;
    tick();
    cmd_adr = 32'h0000_0080;
    tick();
    chk("bp_rsp", 32'(rsp_stb), 32'd1);
    hold_dat = 32'h0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {rsp_dat[31:3], rsp_stb, cmd_rdy, wb_cyc},
          {hold_dat[31:3], 3'b100});
    end
    rsp_rdy = 1'b1;
    tick();
    chk("bp_idle", {30'd0, cmd_rdy, wb_cyc}, 32'd2);
    tick();
    cmd_stb = 1'b0;
    chk("bp_accept", {31'd0, wb_cyc}, 32'd1);
    chk("bp_adr", wb_adr, 32'h0000_0080);
    tick(); tick();
    rsp_rdy = 1'b0;
    ack_at  = 0;
    chk("bp_drain", 32'(cmd_rdy), 32'd1);

    // Interrupt latch, set-wins, and held level after clear
    wb_int = 1'b1;
    tick();
    chk("int_set", 32'(int_pend), 32'd1);
    wb_int = 1'b0;
    tick();
    tick();
    chk("int_keep", 32'(int_pend), 32'd1);
    wb_int = 1'b1; int_clr = 1'b1;
    tick();
    chk("int_setwins", 32'(int_pend), 32'd1);
    tick();
    chk("int_clr", 32'(int_pend), 32'd0);
    int_clr = 1'b0;
    tick(); tick(); tick();
    chk("int_level", 32'(int_pend), 32'd0);
    wb_int = 1'b0;
    tick();

    // Reset in the middle of a bus cycle
    cmd_we = 1'b1; cmd_adr = 32'h0200_0004; cmd_dat = 32'h55;
    ack_at = 0; cmd_stb = 1'b1;
    tick();
    cmd_stb = 1'b0;
    tick();
    chk("rb_cyc", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_drop", {29'd0, wb_cyc, rsp_stb, cmd_rdy}, 32'd1);
    chk("rb_adr", wb_adr, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_stb || wb_cyc) chk("rb_quiet", 32'(rsp_stb), 32'd0);
    end
    chk("rb_idle", 32'(cmd_rdy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
